// File: rtl/e_m_stage_reg_pkg.sv
// Shared E/M stage definitions: ALU control codes, CP0 exception codes and
// architectural PC constants.
package e_m_stage_reg_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // Tnew counts down one per stage and parks at 0 instead of wrapping to 3.
  function automatic logic [1:0] tnew_step(input logic [1:0] tnew);
    return (tnew != 2'd0) ? tnew - 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/e_m_stage_reg_exc_merge.sv
// Priority merge of an inherited exception code with the ALU overflow flags;
// the oldest exception always wins.
module exc_merge #(
  parameter logic [4:0] EXC_OV = e_m_stage_reg_pkg::EXC_OV
) (
  input  logic [4:0] exc_code,
  input  logic       exc_ov_ari,
  input  logic       exc_ov_dm,
  output logic [4:0] merged_code,
  output logic       merged_dm_ov
);

  always_comb begin
    merged_code  = 5'd0;
    merged_dm_ov = 1'b0;
    if (exc_code != 5'd0) begin
      merged_code = exc_code;
    end else if (exc_ov_ari) begin
      merged_code = EXC_OV;
    end else begin
      // Address overflow is left pending so M can pick AdEL vs AdES.
      merged_dm_ov = exc_ov_dm;
    end
  end

endmodule

// File: rtl/e_m_stage_reg.sv
// E->M pipeline register with precise-exception folding, CP0 redirect,
// bubble insertion and hold.
module e_m_stage_reg #(
  parameter logic [31:0] RESET_PC   = e_m_stage_reg_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = e_m_stage_reg_pkg::HANDLER_PC,
  parameter logic [4:0]  EXC_OV     = e_m_stage_reg_pkg::EXC_OV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        flush,
  input  logic        en,
  input  logic [31:0] E_pc,
  input  logic        E_bd,
  input  logic [31:0] E_instr,
  input  logic [4:0]  E_excCode,
  input  logic        E_excOvAri,
  input  logic        E_excOvDM,
  input  logic [31:0] E_ALUout,
  input  logic [31:0] E_rtData,
  input  logic [4:0]  E_regWA,
  input  logic [1:0]  E_Tnew,
  output logic [31:0] M_pc,
  output logic        M_bd,
  output logic [31:0] M_instr,
  output logic [4:0]  M_excCode,
  output logic        M_excDMOv,
  output logic [31:0] M_ALUout,
  output logic [31:0] M_rtData,
  output logic [4:0]  M_regWA,
  output logic [1:0]  M_Tnew
);

  import e_m_stage_reg_pkg::*;

  logic [4:0] merged_code;
  logic       merged_dm_ov;
  logic       faulting;

  exc_merge #(
    .EXC_OV(EXC_OV)
  ) u_exc_merge (
    .exc_code     (E_excCode),
    .exc_ov_ari   (E_excOvAri),
    .exc_ov_dm    (E_excOvDM),
    .merged_code  (merged_code),
    .merged_dm_ov (merged_dm_ov)
  );

  assign faulting = (merged_code != 5'd0);

  always_ff @(posedge clk) begin
    if (reset || req) begin
      M_pc      <= reset ? RESET_PC : HANDLER_PC;
      M_bd      <= 1'b0;
      M_instr   <= 32'd0;
      M_excCode <= 5'd0;
      M_excDMOv <= 1'b0;
      M_ALUout  <= 32'd0;
      M_rtData  <= 32'd0;
      M_regWA   <= 5'd0;
      M_Tnew    <= 2'd0;
    end else if (flush) begin
      // Bubble keeps PC/BD so an interrupt taken on it still reports a valid EPC.
      M_pc      <= E_pc;
      M_bd      <= E_bd;
      M_instr   <= 32'd0;
      M_excCode <= 5'd0;
      M_excDMOv <= 1'b0;
      M_ALUout  <= 32'd0;
      M_rtData  <= 32'd0;
      M_regWA   <= 5'd0;
      M_Tnew    <= 2'd0;
    end else if (en) begin
      M_pc      <= E_pc;
      M_bd      <= E_bd;
      M_instr   <= E_instr;
      M_excCode <= merged_code;
      M_excDMOv <= merged_dm_ov;
      M_ALUout  <= E_ALUout;
      M_rtData  <= E_rtData;
      M_regWA   <= faulting ? 5'd0 : E_regWA;
      M_Tnew    <= faulting ? 2'd0 : tnew_step(E_Tnew);
    end
  end

endmodule

// File: tb/tb_e_m_stage_reg.sv
// Directed self-checking bench for the E->M pipeline register.
module tb_e_m_stage_reg;

  logic        clk = 1'b0;
  logic        reset, req, flush, en;
  logic [31:0] E_pc, E_instr, E_ALUout, E_rtData;
  logic        E_bd, E_excOvAri, E_excOvDM;
  logic [4:0]  E_excCode, E_regWA;
  logic [1:0]  E_Tnew;
  logic [31:0] M_pc, M_instr, M_ALUout, M_rtData;
  logic        M_bd, M_excDMOv;
  logic [4:0]  M_excCode, M_regWA;
  logic [1:0]  M_Tnew;

  int checkCount = 0;
  int failCount  = 0;

  e_m_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush), .en(en),
    .E_pc(E_pc), .E_bd(E_bd), .E_instr(E_instr), .E_excCode(E_excCode),
    .E_excOvAri(E_excOvAri), .E_excOvDM(E_excOvDM), .E_ALUout(E_ALUout),
    .E_rtData(E_rtData), .E_regWA(E_regWA), .E_Tnew(E_Tnew),
    .M_pc(M_pc), .M_bd(M_bd), .M_instr(M_instr), .M_excCode(M_excCode),
    .M_excDMOv(M_excDMOv), .M_ALUout(M_ALUout), .M_rtData(M_rtData),
    .M_regWA(M_regWA), .M_Tnew(M_Tnew)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [31:0] pc, input logic bd,
                            input logic [31:0] instr, input logic [4:0] exc,
                            input logic dmov, input logic [31:0] alu,
                            input logic [31:0] rt, input logic [4:0] wa,
                            input logic [1:0] tnew);
    checkOutput({tag, ".pc"},      M_pc,                pc);
    checkOutput({tag, ".bd"},      {31'd0, M_bd},       {31'd0, bd});
    checkOutput({tag, ".instr"},   M_instr,             instr);
    checkOutput({tag, ".excCode"}, {27'd0, M_excCode},  {27'd0, exc});
    checkOutput({tag, ".excDMOv"}, {31'd0, M_excDMOv},  {31'd0, dmov});
    checkOutput({tag, ".ALUout"},  M_ALUout,            alu);
    checkOutput({tag, ".rtData"},  M_rtData,            rt);
    checkOutput({tag, ".regWA"},   {27'd0, M_regWA},    {27'd0, wa});
    checkOutput({tag, ".Tnew"},    {30'd0, M_Tnew},     {30'd0, tnew});
  endtask

  task automatic driveE(input logic [31:0] pc, input logic bd, input logic [31:0] instr,
                        input logic [4:0] exc, input logic ovA, input logic ovD,
                        input logic [31:0] alu, input logic [31:0] rt,
                        input logic [4:0] wa, input logic [1:0] tnew);
    E_pc = pc; E_bd = bd; E_instr = instr; E_excCode = exc;
    E_excOvAri = ovA; E_excOvDM = ovD; E_ALUout = alu; E_rtData = rt;
    E_regWA = wa; E_Tnew = tnew;
  endtask

  task automatic applyStimulus(input logic rst, input logic rq, input logic fl,
                               input logic enable);
    reset = rst; req = rq; flush = fl; en = enable;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; flush = 1'b0; en = 1'b0;
    driveE(32'h0000_3abc, 1'b1, 32'hdead_beef, 5'd0, 1'b0, 1'b0,
           32'h1111_1111, 32'h2222_2222, 5'd7, 2'd2);
    #1;
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkState("reset", 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);

    driveE(32'h3010, 0, 32'h0085_1020, 0, 0, 0, 32'h7fff_ffff, 32'h1234_5678, 8, 1);
    applyStimulus(0, 0, 0, 1);
    checkState("load1", 32'h3010, 0, 32'h0085_1020, 0, 0, 32'h7fff_ffff, 32'h1234_5678, 8, 0);

    driveE(32'h3014, 1, 32'h2003_0005, 0, 0, 0, 32'h5, 32'h9, 3, 2);
    applyStimulus(0, 0, 0, 1);
    checkState("load2", 32'h3014, 1, 32'h2003_0005, 0, 0, 32'h5, 32'h9, 3, 1);

    driveE(32'h3018, 0, 32'h8c05_0000, 0, 0, 0, 32'h40, 32'h0, 5, 0);
    applyStimulus(0, 0, 0, 1);
    checkState("tnewSat", 32'h3018, 0, 32'h8c05_0000, 0, 0, 32'h40, 32'h0, 5, 0);

    driveE(32'h301c, 0, 32'h0109_4820, 0, 1, 0, 32'h8000_0000, 32'h3, 9, 1);
    applyStimulus(0, 0, 0, 1);
    checkState("ovAri", 32'h301c, 0, 32'h0109_4820, 12, 0, 32'h8000_0000, 32'h3, 0, 0);

    driveE(32'h3020, 0, 32'hffff_ffff, 10, 1, 0, 32'h8000_0000, 32'h3, 9, 2);
    applyStimulus(0, 0, 0, 1);
    checkState("riOverOv", 32'h3020, 0, 32'hffff_ffff, 10, 0, 32'h8000_0000, 32'h3, 0, 0);

    driveE(32'h3024, 0, 32'hac04_0010, 0, 0, 1, 32'h8000_0004, 32'hcafe, 4, 2);
    applyStimulus(0, 0, 0, 1);
    checkState("ovDM", 32'h3024, 0, 32'hac04_0010, 0, 1, 32'h8000_0004, 32'hcafe, 4, 1);

    driveE(32'h3028, 0, 32'h8c04_0010, 4, 0, 1, 32'h8000_0004, 32'hcafe, 4, 2);
    applyStimulus(0, 0, 0, 1);
    checkState("adelOverDM", 32'h3028, 0, 32'h8c04_0010, 4, 0, 32'h8000_0004, 32'hcafe, 0, 0);

    driveE(32'h302c, 0, 32'h0000_0001, 0, 1, 1, 32'h1, 32'h2, 6, 2);
    applyStimulus(0, 0, 0, 1);
    checkState("ariOverDM", 32'h302c, 0, 32'h0000_0001, 12, 0, 32'h1, 32'h2, 0, 0);

    driveE(32'h3020, 1, 32'h0123_4567, 10, 1, 1, 32'haaaa_aaaa, 32'hbbbb_bbbb, 11, 2);
    applyStimulus(0, 0, 1, 1);
    checkState("flush", 32'h3020, 1, 0, 0, 0, 0, 0, 0, 0);

    driveE(32'h3030, 1, 32'h0230_8021, 0, 0, 0, 32'h55, 32'h66, 16, 2);
    applyStimulus(0, 0, 0, 1);
    checkState("preHold", 32'h3030, 1, 32'h0230_8021, 0, 0, 32'h55, 32'h66, 16, 1);

    for (int i = 0; i < 3; i++) begin
      driveE(32'h4000 + 32'(i * 4), i[0], 32'hf0f0_0000 + 32'(i), 5'(i + 1), 1'(i), 1,
             32'h9999_0000 + 32'(i), 32'h7777_0000 + 32'(i), 5'(20 + i), 2'(i));
      applyStimulus(0, 0, 0, 0);
      checkState($sformatf("hold%0d", i), 32'h3030, 1, 32'h0230_8021, 0, 0,
                 32'h55, 32'h66, 16, 1);
    end

    driveE(32'h3034, 1, 32'h0109_4820, 0, 1, 0, 32'h1234, 32'h5678, 9, 1);
    applyStimulus(0, 1, 1, 1);
    checkState("req", 32'h4180, 0, 0, 0, 0, 0, 0, 0, 0);

    driveE(32'h3038, 0, 32'h0043_0821, 0, 0, 0, 32'habcd, 32'h0, 1, 2);
    applyStimulus(0, 0, 0, 1);
    checkState("postReq", 32'h3038, 0, 32'h0043_0821, 0, 0, 32'habcd, 32'h0, 1, 1);

    driveE(32'h303c, 1, 32'h0043_0821, 0, 0, 0, 32'hbeef, 32'h77, 2, 2);
    applyStimulus(1, 1, 1, 1);
    checkState("midReset", 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 1);
    checkState("postReset", 32'h303c, 1, 32'h0043_0821, 0, 0, 32'hbeef, 32'h77, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/e_m_stage_reg.md
Name: e_m_stage_reg

Overview:
- Pipeline register between the E stage (ALU, MDU) and the M stage of the five-stage MIPS core.
- Captures the E-stage results: ALU result, forwarded store data, destination register, Tnew and PC/BD.
- Folds the ALU overflow flags into the precise-exception fields consumed by M and CP0.
- Honours the CP0 exception request, bubble insertion (flush) and hold, with a fixed priority.

Parameters:
RESET_PC, 32'h0000_3000, M_pc value after reset
HANDLER_PC, 32'h0000_4180, M_pc value loaded on CP0 req
EXC_OV, 5'd12, ExcCode written for arithmetic overflow

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
req  in  1  CP0 exception/interrupt taken this cycle
flush  in  1  insert bubble into M
en  in  1  1 = load, 0 = hold current contents
E_pc  in  32  instruction PC
E_bd  in  1  instruction is in a branch delay slot
E_instr  in  32  instruction word
E_excCode  in  5  exception code carried from F/D; 0 = none
E_excOvAri  in  1  ALU arithmetic overflow (add/addi/sub)
E_excOvDM  in  1  ALU address-calculation overflow (load/store)
E_ALUout  in  32  ALU or MDU-selected result
E_rtData  in  32  forwarded rt value (store data)
E_regWA  in  5  destination GPR; 0 = no write
E_Tnew  in  2  cycles until the result is ready, as seen in E
M_pc  out  32
M_bd  out  1
M_instr  out  32
M_excCode  out  5
M_excDMOv  out  1  address overflow pending; M turns it into AdEL/AdES
M_ALUout  out  32
M_rtData  out  32
M_regWA  out  5
M_Tnew  out  2

Behaviour:
- All updates occur on the rising edge of clk. Outputs are driven directly by registers, with no combinational path from input to output.
- Priority, highest first: reset > req > flush > en==0 > load.
- reset:
  - M_pc = RESET_PC.
  - Every other output = 0, including M_bd, M_excCode, M_excDMOv and M_Tnew.
- req:
  - Registers a bubble with M_pc = HANDLER_PC.
  - Every other output = 0.
  - req overrides flush, en and all data inputs in the same cycle.
- flush (req = 0):
  - Registers a bubble with M_pc = E_pc and M_bd = E_bd, so a later interrupt still yields a correct EPC/BD.
  - M_instr = 0, M_regWA = 0, M_Tnew = 0, M_excCode = 0, M_excDMOv = 0.
  - M_ALUout and M_rtData = 0.
- en = 0 (no reset, req or flush): all outputs hold their values.
- load (en = 1):
  - M_pc, M_bd, M_instr, M_ALUout, M_rtData and M_regWA take the E inputs.
  - M_Tnew = E_Tnew − 1 when E_Tnew > 0, otherwise 0. It saturates at 0 and never wraps to 3.
  - Exception merge:
    - If E_excCode != 0: M_excCode = E_excCode and M_excDMOv = 0. The earlier exception wins.
    - Else if E_excOvAri: M_excCode = EXC_OV and M_excDMOv = 0.
    - Else: M_excCode = 0 and M_excDMOv = E_excOvDM.
    - If E_excOvAri and E_excOvDM are both 1 (illegal control), E_excOvAri wins.
  - If the merged M_excCode != 0, M_regWA is forced to 0 and M_Tnew to 0, so a faulting instruction never writes back or forwards.
- Latency: exactly 1 cycle from E input to M output; there is no other internal state.
- A reset or req asserted for a single cycle takes effect at that edge. The next edge resumes normal priority.

Decomposition:
- Shared header, alongside the ALU control codes:
  - ExcCode constants EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
  - RESET_PC and HANDLER_PC.
- One natural sub-module, exc_merge: a combinational priority merge of E_excCode, E_excOvAri and E_excOvDM into excCode and excDMOv. It is reusable by the M/W register.
- The register bank stays in e_m_stage_reg.

Test Plan:
- reset = 1 for 2 cycles -> M_pc = 0x3000, every other output 0. The same holds when reset is asserted mid-stream with en = 1 and valid data.
- Load: en = 1, E_pc = 0x3010, E_ALUout = 0x7FFF_FFFF, E_regWA = 8, E_Tnew = 1, no exceptions -> the next cycle shows M_ALUout = 0x7FFF_FFFF, M_regWA = 8, M_Tnew = 0, M_excCode = 0.
- Overflow: E_excOvAri = 1, E_regWA = 9, E_Tnew = 1 -> M_excCode = 12, M_regWA = 0, M_Tnew = 0. Repeat with E_excCode = 10 and E_excOvAri = 1 -> M_excCode = 10.
- Address overflow: E_excOvDM = 1, E_excCode = 0 -> M_excDMOv = 1, M_excCode = 0. With E_excCode = 4 as well -> M_excDMOv = 0, M_excCode = 4.
- Flush vs hold:
  - flush = 1, E_pc = 0x3020, E_bd = 1 -> M_pc = 0x3020, M_bd = 1, M_instr = 0, M_regWA = 0.
  - en = 0 for 3 cycles with changing inputs -> outputs unchanged.
- req priority: req = 1 with flush = 1, en = 1, E_excOvAri = 1 -> M_pc = 0x4180, all other outputs 0. The next cycle, with req = 0, loads normally.
